// File: rtl/divu_p6y3_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Results (q/r/dbz) are held until the next accepted start; valid pulses once per result.
module divu_p6y3_seq #(
  parameter int P_WIDTH = 6,
  parameter int Y_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [P_WIDTH-1:0] p,
  input  logic [Y_WIDTH-1:0] y,
  output logic [P_WIDTH-1:0] q,
  output logic [Y_WIDTH-1:0] r,
  output logic               dbz,
  output logic               valid,
  output logic               rdy
);

  localparam int CW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [P_WIDTH-1:0] dvd_q, dvd_d;
  logic [Y_WIDTH-1:0] div_q, div_d;
  logic [Y_WIDTH-1:0] part_q, part_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [P_WIDTH-1:0] quo_q, quo_d;
  logic [Y_WIDTH-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [Y_WIDTH:0]   shifted;
  logic [Y_WIDTH:0]   diff;
  logic               ge;
  logic [Y_WIDTH-1:0] nextPart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (y == '0) ? DONE : BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy   = (state_q == IDLE);
    valid = (state_q == DONE);
  end

  // The stored partial remainder is always < divisor, so it fits Y_WIDTH bits;
  // only the shifted working value needs the extra bit.
  always_comb begin
    shifted  = {part_q, dvd_q[P_WIDTH-1]};
    diff     = shifted - {1'b0, div_q};
    ge       = (shifted >= {1'b0, div_q});
    nextPart = Y_WIDTH'(ge ? diff : shifted);
  end

  always_comb begin
    dvd_d  = dvd_q;
    div_d  = div_q;
    part_d = part_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (y != '0) begin
            dvd_d  = p;
            div_d  = y;
            part_d = '0;
            cnt_d  = CW'(P_WIDTH - 1);
          end else begin
            quo_d = '1;
            rem_d = '0;
            dbz_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // Dividend bits shift out the top while quotient bits shift in the bottom.
        part_d = nextPart;
        dvd_d  = {dvd_q[P_WIDTH-2:0], ge};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quo_d = {dvd_q[P_WIDTH-2:0], ge};
          rem_d = nextPart;
          dbz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      div_q  <= '0;
      part_q <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      div_q  <= div_d;
      part_q <= part_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign q   = quo_q;
  assign r   = rem_q;
  assign dbz = dbz_q;

endmodule
